// File: rtl/tile_map_render_if.sv
// Map-port bus between a CPU-side master and the tile map renderer.
// Carries the cell write strobe/address/data, the whole-map clear pulse and
// the busy flag the renderer returns while a clear sweeps the map.
//   master : drives map_we, map_addr, map_wdata, map_clear; reads map_busy
//   slave  : reads map_we, map_addr, map_wdata, map_clear; drives map_busy
interface tile_map_render_if #(
    parameter int IDX_W  = 10,
    parameter int TYPE_W = 2
) ();
    logic              map_we;
    logic [IDX_W-1:0]  map_addr;
    logic [TYPE_W-1:0] map_wdata;
    logic              map_clear;
    logic              map_busy;

    modport master (
        output map_we,
        output map_addr,
        output map_wdata,
        output map_clear,
        input  map_busy
    );

    modport slave (
        input  map_we,
        input  map_addr,
        input  map_wdata,
        input  map_clear,
        output map_busy
    );
endinterface

// File: rtl/tile_map_render.sv
// Tile-based playfield renderer.
// Turns the timing generator's pixel_column/pixel_row into a per-pixel colour.
// A writable map RAM holds one tile type per screen cell. The texture for that
// type comes from an external tile ROM addressed with {type, row_off, col_off}.
// Input-to-output latency is 3+ROM_LATENCY cycles at one pixel per cycle.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   pixel_column/row    : current pixel position (12 bits each)
//   video_on            : active-video qualifier
//   mapBus (slave)      : CPU map write / clear port, map_busy while clearing
//   rom_addr / rom_data : tile ROM address out, texel back ROM_LATENCY cycles later
//   pix_color/opaque/valid : rendered pixel, non-empty flag, qualified valid
module tile_map_render #(
    parameter int                 TILE_LOG2   = 5,
    parameter int                 MAP_COLS    = 32,
    parameter int                 MAP_ROWS    = 24,
    parameter int                 TYPE_W      = 2,
    parameter int                 COLOR_W     = 12,
    parameter int                 ROM_LATENCY = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR    = 12'h000,
    parameter int                 IDX_W       = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [11:0]                     pixel_column,
    input  logic [11:0]                     pixel_row,
    input  logic                            video_on,
    tile_map_render_if.slave                mapBus,
    output logic [TYPE_W+2*TILE_LOG2-1:0]   rom_addr,
    input  logic [COLOR_W-1:0]              rom_data,
    output logic [COLOR_W-1:0]              pix_color,
    output logic                            pix_opaque,
    output logic                            pix_valid
);

    localparam int DEPTH = MAP_COLS * MAP_ROWS;

    typedef enum logic {IDLE, CLEAR} clrState_t;

    // Map storage; deliberately has no reset so a reset mid-clear leaves it
    // partially cleared.
    logic [TYPE_W-1:0] mapMem [0:DEPTH-1];

    logic [11:0]          colCell;
    logic [11:0]          rowCell;
    logic [TILE_LOG2-1:0] colOff;
    logic [TILE_LOG2-1:0] rowOff;
    logic                 inMap;
    logic [IDX_W-1:0]     idx1_d;

    logic [IDX_W-1:0]     idx1_q;
    logic [TILE_LOG2-1:0] colOff1_q;
    logic [TILE_LOG2-1:0] rowOff1_q;
    logic                 v1_q;

    logic [TYPE_W-1:0]    type2_q;
    logic [TILE_LOG2-1:0] colOff2_q;
    logic [TILE_LOG2-1:0] rowOff2_q;
    logic                 v2_q;

    logic [TYPE_W-1:0]    typeDly_q [ROM_LATENCY];
    logic                 vDly_q    [ROM_LATENCY];

    logic                 pixOpaque_d;
    logic [COLOR_W-1:0]   pixColor_d;
    logic                 pixOpaque_q;
    logic [COLOR_W-1:0]   pixColor_q;
    logic                 pixValid_q;

    clrState_t            state_q;
    clrState_t            state_d;
    logic [IDX_W-1:0]     count_q;
    logic [IDX_W-1:0]     count_d;
    logic                 ramWe;
    logic [IDX_W-1:0]     ramAddr;
    logic [TYPE_W-1:0]    ramData;

    // Split the pixel position into cell and in-cell offset with shifts only.
    // Off-map pixels use index 0 so no out-of-range address reaches the RAM.
    always_comb begin
        colCell = pixel_column >> TILE_LOG2;
        rowCell = pixel_row >> TILE_LOG2;
        colOff  = pixel_column[TILE_LOG2-1:0];
        rowOff  = pixel_row[TILE_LOG2-1:0];
        inMap   = (int'(colCell) < MAP_COLS) && (int'(rowCell) < MAP_ROWS);
        idx1_d  = '0;
        if (inMap) begin
            idx1_d = IDX_W'(int'(rowCell) * MAP_COLS + int'(colCell));
        end
    end

    // Render pipeline: cell index, synchronous map read, ROM-latency delay
    // line for type/valid, then the output register aligned with rom_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx1_q      <= '0;
            colOff1_q   <= '0;
            rowOff1_q   <= '0;
            v1_q        <= 1'b0;
            type2_q     <= '0;
            colOff2_q   <= '0;
            rowOff2_q   <= '0;
            v2_q        <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                typeDly_q[i] <= '0;
                vDly_q[i]    <= 1'b0;
            end
            pixOpaque_q <= 1'b0;
            pixColor_q  <= BG_COLOR;
            pixValid_q  <= 1'b0;
        end else begin
            idx1_q      <= idx1_d;
            colOff1_q   <= colOff;
            rowOff1_q   <= rowOff;
            v1_q        <= video_on && inMap;
            type2_q     <= mapMem[idx1_q];
            colOff2_q   <= colOff1_q;
            rowOff2_q   <= rowOff1_q;
            v2_q        <= v1_q;
            typeDly_q[0] <= type2_q;
            vDly_q[0]    <= v2_q;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                typeDly_q[i] <= typeDly_q[i-1];
                vDly_q[i]    <= vDly_q[i-1];
            end
            pixOpaque_q <= pixOpaque_d;
            pixColor_q  <= pixColor_d;
            pixValid_q  <= vDly_q[ROM_LATENCY-1];
        end
    end

    always_comb begin
        pixOpaque_d = vDly_q[ROM_LATENCY-1] && (typeDly_q[ROM_LATENCY-1] != '0);
        pixColor_d  = pixOpaque_d ? rom_data : BG_COLOR;
    end

    // Single map write port. The read of type2_q above sees the old contents
    // on a same-address collision (read-first).
    always_ff @(posedge clock) begin
        if (ramWe) begin
            mapMem[ramAddr] <= ramData;
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Clear sequencing and write-port arbitration. While clearing, the
    // sweep owns the write port and CPU writes/clears are dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ramWe   = 1'b0;
        ramAddr = mapBus.map_addr;
        ramData = mapBus.map_wdata;
        case (state_q)
            IDLE: begin
                if (mapBus.map_we && (int'(mapBus.map_addr) < DEPTH)) begin
                    ramWe = 1'b1;
                end
                if (mapBus.map_clear) begin
                    state_d = CLEAR;
                    count_d = '0;
                end
            end
            CLEAR: begin
                ramWe   = 1'b1;
                ramAddr = count_q;
                ramData = '0;
                count_d = count_q + 1'b1;
                if (count_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mapBus.map_busy = (state_q == CLEAR);
    assign rom_addr   = {type2_q, rowOff2_q, colOff2_q};
    assign pix_color  = pixColor_q;
    assign pix_opaque = pixOpaque_q;
    assign pix_valid  = pixValid_q;

endmodule

// File: doc/tile_map_render.md
Name: tile_map_render

Overview:
Parametrised tile-based playfield renderer and successor of the single-brick texture lookup. It converts the display timing generator's pixel_column/pixel_row into a per-pixel colour. Each screen cell carries a writable tile type held in an internal map RAM, so brick, steel, water and other tiles can sit anywhere on the map. The texture for each type comes from an external tile ROM. Output feeds the colourizer/overlay mux beside the tank and bullet sprites.

Parameters:
TILE_LOG2, 5, tile edge = 2^TILE_LOG2 pixels (32)
MAP_COLS, 32, cells per map row
MAP_ROWS, 24, cells per map column
TYPE_W, 2, tile type width; type 0 = empty
COLOR_W, 12, RGB colour width
ROM_LATENCY, 1, tile ROM read latency in cycles (1..3)
BG_COLOR, 12'h000, colour for empty or off-map pixels
IDX_W, 10, map address width, >= clog2(MAP_COLS*MAP_ROWS)

Ports:
clock  in  1  pixel/system clock, rising edge
reset  in  1  asynchronous, active-low reset
pixel_column  in  12  current pixel x from the timing generator
pixel_row  in  12  current pixel y from the timing generator
video_on  in  1  active-video qualifier
map_we  in  1  CPU map write strobe
map_addr  in  IDX_W  cell index = row*MAP_COLS + col
map_wdata  in  TYPE_W  tile type to write
map_clear  in  1  one-cycle pulse: zero the whole map
map_busy  out  1  clear sequence in progress
rom_addr  out  TYPE_W+2*TILE_LOG2  {type, row_off, col_off} to the tile ROM
rom_data  in  COLOR_W  ROM texel, valid ROM_LATENCY cycles after rom_addr
pix_color  out  COLOR_W  rendered colour
pix_opaque  out  1  pixel lies on a non-empty tile
pix_valid  out  1  delayed video_on qualified by in-map

Behaviour:
- Cell coordinates: col_cell = pixel_column >> TILE_LOG2, col_off = pixel_column[TILE_LOG2-1:0]. row_cell and row_off come from pixel_row in the same way. No dividers. Row offset is taken from pixel_row only.
- in_map = (col_cell < MAP_COLS) && (row_cell < MAP_ROWS).
- Pipeline:
  - Edge 1 registers idx = row_cell*MAP_COLS + col_cell, both offsets, and v = video_on && in_map. When in_map = 0, idx is forced to 0.
  - Edge 2: the map RAM does a synchronous read of idx into the stage-2 type register. Offsets and v advance with it.
  - rom_addr is driven combinationally from the stage-2 registers.
  - Type and v are delayed by ROM_LATENCY stages to align with rom_data.
  - Output register at edge 3+ROM_LATENCY. Total input-to-output latency L = 3+ROM_LATENCY cycles (default 4). Throughput is 1 pixel/cycle, with no stalls.
- Output: pix_opaque = v && type != 0. pix_color = pix_opaque ? rom_data : BG_COLOR. pix_valid = v.
- Map RAM: MAP_COLS*MAP_ROWS x TYPE_W, one write port and one read port. Read-first: a read and a write to the same address in the same cycle returns the old data, and the new data is visible on the next read. Writes with map_addr >= MAP_COLS*MAP_ROWS are dropped. RAM contents are not affected by reset.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on map_clear. Counter is set to 0 and map_busy = 1 from the next cycle.
  - In CLEAR, one zero is written per cycle at the counter address, then the counter increments.
  - After the write to the last address (MAP_COLS*MAP_ROWS-1), the FSM returns to IDLE and map_busy drops. Clear takes exactly MAP_COLS*MAP_ROWS cycles.
  - In CLEAR, map_we is ignored (writes are lost) and map_clear is ignored (no restart).
  - If map_we and map_clear arrive in the same IDLE cycle, the write happens and the clear starts next cycle, so the write is overwritten.
  - Rendering continues during a clear; reads may return either pre-clear or zeroed types.
- Reset (async assert, sync release): all pipeline registers are 0, so pix_valid=0, pix_opaque=0, pix_color=BG_COLOR. rom_addr=0, FSM=IDLE, map_busy=0, counter=0. Reset in the middle of a clear aborts it and leaves the map partially cleared.

Test Plan:
- Write type 1 to idx 0, hold (col,row)=(5,7) with video_on=1 -> rom_addr={1,7,5}. L=4 cycles later pix_color = ROM texel, pix_opaque=1, pix_valid=1.
- Write type 2 to idx 33 (cell col 1, row 1), scan pixel_column 32..63 on row 40 -> col_off 0..31 and row_off 8. Output tracks the input at exactly 4-cycle latency, back-to-back. Row offset must depend on pixel_row only.
- pixel_column=1024 or pixel_row=768, or video_on=0 -> pix_valid=0, pix_color=12'h000. No map index outside 0..767 reaches the RAM.
- Fill the map with type 3, pulse map_clear -> map_busy is high for exactly 768 cycles. A map_we during busy is lost. Afterwards every cell reads type 0, giving pix_opaque=0 and BG colour.
- Same-cycle write and render read of idx 10 -> the read returns the old type and the following read returns the new one. Repeat with ROM_LATENCY=3 -> L=6.
- Assert reset 100 cycles into a clear -> outputs take their reset values immediately and map_busy=0. Cells 0..99 read 0 and cell 100 onward keep their old types.
